// File: rtl/mem_responder.sv
// mem_responder: word-organised memory slave with wait states, byte enables and misalignment flag
module mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  memReq,
  input  logic                  memWrite,
  input  logic [31:0]           memAddr,
  input  logic [DATA_WIDTH-1:0] memWData,
  input  logic [3:0]            memByteEn,
  output logic                  memReady,
  output logic [DATA_WIDTH-1:0] memRData,
  output logic                  memError,
  output logic                  memBusy
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] LAT_M1 = LATENCY == 0 ? 4'd0 : 4'(LATENCY - 1);
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic l_wr;
  logic [ADDR_WIDTH+1:0] l_addr;
  logic [DATA_WIDTH-1:0] l_wdata;
  logic [3:0] l_be;
  logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic mis, accept, unused_addr;
  // upper address bits are deliberately dropped so the memory aliases modulo depth
  assign unused_addr = ^memAddr[31:ADDR_WIDTH+2];
  assign idx = l_addr[ADDR_WIDTH+1:2];
  assign mis = |l_addr[1:0];
  assign accept = state == IDLE && memReq;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    case (state)
      IDLE: if (memReq) begin
        state_nx = LATENCY == 0 ? RESP : WAIT;
        cnt_nx = LAT_M1;
      end
      WAIT: if (cnt == 4'd0) state_nx = RESP; else cnt_nx = cnt - 4'd1;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      l_wr <= 1'b0;
      l_addr <= '0;
      l_wdata <= '0;
      l_be <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (accept) begin
        l_wr <= memWrite;
        l_addr <= memAddr[ADDR_WIDTH+1:0];
        l_wdata <= memWData;
        l_be <= memByteEn;
      end
    end
  end
  // commit happens on the edge that ends RESP; an earlier async reset leaves RESP unreached
  always_ff @(posedge clk) begin
    if (memReady && l_wr && !mis)
      for (int i = 0; i < 4; i++)
        if (l_be[i]) ram[idx][8*i +: 8] <= l_wdata[8*i +: 8];
  end
  assign memReady = state == RESP;
  assign memBusy = state != IDLE;
  assign memError = memReady && mis;
  assign memRData = (memReady && !mis && !l_wr) ? ram[idx] : '0;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: drives three responders (LATENCY 2, 0, 4) and checks them against a word-array model
module tb_mem_responder;
  logic clk = 1'b0;
  logic rst_n [3];
  logic req [3];
  logic wr [3];
  logic [31:0] addr [3];
  logic [31:0] wdat [3];
  logic [3:0] ben [3];
  logic rdy [3];
  logic [31:0] rdat [3];
  logic err [3];
  logic busy [3];
  logic [31:0] mdl [3][256];
  int n_cmp = 0;
  int n_mis = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : u
    mem_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .LATENCY(g == 0 ? 2 : g == 1 ? 0 : 4)) dut (
      .clk(clk), .rst_n(rst_n[g]), .memReq(req[g]), .memWrite(wr[g]), .memAddr(addr[g]),
      .memWData(wdat[g]), .memByteEn(ben[g]), .memReady(rdy[g]), .memRData(rdat[g]),
      .memError(err[g]), .memBusy(busy[g])
    );
  end
  function automatic int lat_of(input int k);
    return k == 0 ? 2 : k == 1 ? 0 : 4;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic txn(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input bit perturb);
    logic [31:0] exp_d;
    bit exp_e, got, bad;
    int idx, n;
    exp_e = (a % 4) != 0;
    idx = (a / 4) % 256;
    exp_d = (!w && !exp_e) ? mdl[k][idx] : 32'h0;
    @(negedge clk);
    req[k] = 1'b1; wr[k] = w; addr[k] = a; wdat[k] = d; ben[k] = be;
    @(posedge clk);
    n = 0; got = 0; bad = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (perturb && n == 1) begin
        addr[k] = $urandom; wr[k] = 1'($urandom); wdat[k] = $urandom; ben[k] = 4'($urandom);
      end
      if (rdy[k]) got = 1;
      else if (!busy[k] || rdat[k] !== 32'h0 || err[k] !== 1'b0) bad = 1;
    end
    chk("resp_seen", 32'(got), 32'd1);
    chk("wait_outputs_bad", 32'(bad), 32'd0);
    chk("latency", n, lat_of(k) + 1);
    chk("rdata", rdat[k], exp_d);
    chk("error", 32'(err[k]), 32'(exp_e));
    chk("busy_resp", 32'(busy[k]), 32'd1);
    req[k] = 1'b0;
    if (w && !exp_e)
      for (int i = 0; i < 4; i++)
        if (be[i]) mdl[k][idx][8*i +: 8] = d[8*i +: 8];
    @(negedge clk);
    chk("ready_one_cycle", 32'(rdy[k]), 32'd0);
    chk("busy_idle", 32'(busy[k]), 32'd0);
  endtask
  initial begin
    logic [31:0] a;
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; req[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wdat[k] = '0; ben[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", 32'(rdy[k]), 32'd0);
      chk("rst_rdata", rdat[k], 32'h0);
      chk("rst_error", 32'(err[k]), 32'd0);
      chk("rst_busy", 32'(busy[k]), 32'd0);
      rst_n[k] = 1'b1;
    end
    for (int k = 0; k < 3; k++)
      for (int w = 0; w < 256; w++) txn(k, 1, 32'(w * 4), $urandom, 4'hF, 0);
    // directed: basic read with wait states
    txn(0, 1, 32'h0C, 32'hDEADBEEF, 4'hF, 0);
    txn(0, 0, 32'h0C, 32'h0, 4'h0, 0);
    // byte-lane merge
    txn(0, 1, 32'h10, 32'h11223344, 4'hF, 0);
    txn(0, 1, 32'h10, 32'hAABBCCDD, 4'b0101, 0);
    txn(0, 0, 32'h10, 32'h0, 4'h0, 0);
    chk("merge_model", mdl[0][4], 32'h11BB33DD);
    txn(0, 1, 32'h10, 32'h55555555, 4'h0, 0);
    txn(0, 0, 32'h10, 32'h0, 4'h0, 0);
    // misalignment
    txn(0, 0, 32'h06, 32'h0, 4'h0, 0);
    txn(0, 1, 32'h05, 32'hFFFFFFFF, 4'hF, 0);
    txn(0, 0, 32'h04, 32'h0, 4'h0, 0);
    // zero-latency back-to-back with memReq held high
    @(negedge clk);
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 32'h20;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("b2b_ready", 32'(rdy[1]), 32'(i % 2));
      chk("b2b_rdata", rdat[1], (i % 2) ? mdl[1][8] : 32'h0);
    end
    req[1] = 1'b0;
    @(negedge clk);
    // aliasing modulo depth
    txn(1, 1, 32'h400, 32'hC0FFEE01, 4'hF, 0);
    txn(1, 0, 32'h000, 32'h0, 4'h0, 0);
    chk("alias_model", mdl[1][0], 32'hC0FFEE01);
    // reset mid-WAIT aborts the pending write
    @(negedge clk);
    req[2] = 1'b1; wr[2] = 1'b1; addr[2] = 32'h40; wdat[2] = ~mdl[2][16]; ben[2] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req[2] = 1'b0;
    @(negedge clk);
    chk("pre_abort_busy", 32'(busy[2]), 32'd1);
    rst_n[2] = 1'b0;
    #1;
    chk("abort_ready", 32'(rdy[2]), 32'd0);
    chk("abort_busy", 32'(busy[2]), 32'd0);
    chk("abort_rdata", rdat[2], 32'h0);
    chk("abort_error", 32'(err[2]), 32'd0);
    @(negedge clk);
    rst_n[2] = 1'b1;
    @(negedge clk);
    chk("post_abort_busy", 32'(busy[2]), 32'd0);
    txn(2, 0, 32'h40, 32'h0, 4'h0, 0);
    // inputs changing during WAIT are ignored
    txn(0, 1, 32'h84, 32'h13572468, 4'b1010, 1);
    txn(0, 0, 32'h84, 32'h0, 4'h0, 1);
    txn(2, 1, 32'h88, 32'h0BADF00D, 4'hF, 1);
    txn(2, 0, 32'h88, 32'h0, 4'h0, 1);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      a = $urandom;
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      txn(i % 3, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(3) == 0);
    end
    for (int k = 0; k < 3; k++)
      for (int w = 0; w < 256; w += 17) txn(k, 0, 32'(w * 4), 32'h0, 4'h0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Word-organised memory slave that answers the multicycle core controller's instruction-fetch and load/store requests over a req/ready handshake.
- Sits on the memory side of the datapath: the controller/datapath is the initiator and this block is the responder.
- Provides programmable wait-state latency, byte-enabled writes and misalignment detection, so controller stall behaviour can be exercised.

Parameters:
- ADDR_WIDTH, 8, number of word-address bits; memory depth is 2**ADDR_WIDTH words.
- DATA_WIDTH, 32, word width in bits; fixed at 32 for byte-enable mapping.
- LATENCY, 2, wait cycles between acceptance and response; legal range 0..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- memReq  in  1  request valid; held by the initiator until memReady.
- memWrite  in  1  1 = write, 0 = read; sampled at acceptance.
- memAddr  in  32  byte address; sampled at acceptance.
- memWData  in  32  write data; sampled at acceptance.
- memByteEn  in  4  write byte lanes; bit i enables bits [8i+7:8i]; ignored on reads.
- memReady  out  1  one-cycle response strobe.
- memRData  out  32  read data; valid only while memReady=1.
- memError  out  1  misaligned-access flag; valid only while memReady=1.
- memBusy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, counter=0.
  - memReady=0, memRData=0, memError=0, memBusy=0.
  - RAM contents are not cleared.
  - Reset asserted mid-transaction aborts it; a pending write is never committed.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If memReq=1 at a clock edge, latch memWrite, memAddr, memWData and memByteEn, then:
    - LATENCY=0: go to RESP.
    - Otherwise: load counter=LATENCY-1 and go to WAIT.
  - If memReq=0, remain in IDLE.
- WAIT:
  - If counter=0, go to RESP; else decrement counter.
  - Input changes during WAIT are ignored; the latched values govern the transaction.
- RESP:
  - memReady=1 for exactly one cycle, registered (no combinational path from memReq).
  - Unconditional transition back to IDLE.
- Latency from the acceptance edge to the memReady=1 cycle is LATENCY+1 cycles.
- Word index is latchedAddr[ADDR_WIDTH+1:2]; higher address bits are ignored, so the memory aliases (wraps) modulo depth.
- Misalignment (latchedAddr[1:0]!=0):
  - memError=1 in the RESP cycle.
  - No RAM write; memRData=0.
- Aligned read: memRData = RAM[index] in the RESP cycle; memError=0.
- Aligned write:
  - RAM lanes with byte-enable=1 are updated at the end of the RESP cycle; other lanes are unchanged.
  - memRData=0.
  - memByteEn=0000 completes normally with no change.
- Outside RESP, memReady=0, memRData=0 and memError=0.
- Back-to-back: the initiator drops memReq in the cycle after memReady. If memReq is still 1 in the IDLE cycle following RESP, it is accepted as a new request. Minimum spacing is one IDLE cycle per transaction.
- Read-after-write to the same word returns the newly written data.

Test Plan:
1. LATENCY=2, RAM[3]=0xDEADBEEF, read memAddr=0x0C → memReady high in the 3rd cycle after acceptance with memRData=0xDEADBEEF, memError=0; memBusy high for 3 cycles.
2. Write 0x11223344 to 0x10 with memByteEn=1111, then write 0xAABBCCDD to 0x10 with memByteEn=0101, then read 0x10 → memRData=0x11BB33DD.
3. Read 0x06 (misaligned) → memReady=1, memError=1, memRData=0. Write 0xFFFFFFFF to 0x05 → memError=1 and a subsequent read of 0x04 shows the word unchanged.
4. LATENCY=0, memReq held high continuously → transactions alternate IDLE/RESP with memReady every 2nd cycle. Alias check: write to 0x400 with ADDR_WIDTH=8 is readable at 0x000.
5. Accept a write with LATENCY=4, assert rst_n=0 during WAIT → outputs 0 immediately and state is IDLE after release; reading the target word shows its old value.
6. During WAIT, change memAddr/memWrite/memWData → the response and RAM update reflect only the values latched at acceptance.
